// File: rtl/scan_ppi_ppo_if.sv
// Bundle of the handshake and data signals between the scan controller and
// whatever drives it (tester logic on one side, the flop-stripped core on
// the other).
//   master : drives test_mode, start, pat_in and the core's ppo.
//            Observes ppi, scan_so, busy, resp_out and resp_valid.
//   slave  : the controller. It samples the master outputs and drives the
//            observation signals.
interface scan_ppi_ppo_if #(
    parameter int N_FF = 2
);
    logic            test_mode;
    logic            start;
    logic [N_FF-1:0] pat_in;
    logic [N_FF-1:0] ppo;
    logic [N_FF-1:0] ppi;
    logic            scan_so;
    logic            busy;
    logic [N_FF-1:0] resp_out;
    logic            resp_valid;

    modport master (
        output test_mode, start, pat_in, ppo,
        input  ppi, scan_so, busy, resp_out, resp_valid
    );

    modport slave (
        input  test_mode, start, pat_in, ppo,
        output ppi, scan_so, busy, resp_out, resp_valid
    );
endinterface

// File: rtl/scan_ppi_ppo_ctrl.sv
// Scan-side owner of the state flops stripped out of a combinational core.
// In functional mode the chain register acts as the original state register
// (ppi <= ppo every edge). In test mode the controller runs a sequence:
// it shifts a pattern into the chain serially, captures one core response,
// shifts that response out, and publishes it.
// Ports:
//   clk    : single clock; all state changes on the rising edge
//   rst_n  : synchronous, active-low reset
//   bus    : slave side of scan_ppi_ppo_if
//            (test_mode, start, pat_in, ppo in;
//             ppi, scan_so, busy, resp_out, resp_valid out)
module scan_ppi_ppo_ctrl #(
    parameter int N_FF = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    scan_ppi_ppo_if.slave     bus
);
    localparam int CW = $clog2(N_FF) + 1;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] LOAD    = 3'd1;
    localparam logic [2:0] CAPTURE = 3'd2;
    localparam logic [2:0] UNLOAD  = 3'd3;
    localparam logic [2:0] DONE    = 3'd4;

    localparam logic [CW-1:0] CNT_LAST = CW'(N_FF - 1);

    logic [2:0]      state;
    logic [CW-1:0]   cnt;
    logic [N_FF-1:0] chain;
    logic [N_FF-1:0] pat_sr;
    logic [N_FF-1:0] resp_sr;
    logic [N_FF-1:0] resp_out;

    // Shift right by one and insert a bit at the MSB. Written this way so
    // that N_FF=1 needs no zero-width slice.
    function automatic logic [N_FF-1:0] shift_in(input logic [N_FF-1:0] v,
                                                 input logic            b);
        logic [N_FF-1:0] r;
        r         = v >> 1;
        r[N_FF-1] = b;
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            chain    <= '0;
            pat_sr   <= '0;
            resp_sr  <= '0;
            resp_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!bus.test_mode) begin
                        chain <= bus.ppo;
                    end else if (bus.start) begin
                        pat_sr <= bus.pat_in;
                        cnt    <= '0;
                        state  <= LOAD;
                    end
                end

                LOAD: begin
                    // Leaving test mode abandons the sequence. The chain
                    // keeps its value on that edge.
                    if (!bus.test_mode) begin
                        state <= IDLE;
                    end else begin
                        chain  <= shift_in(chain, pat_sr[0]);
                        pat_sr <= pat_sr >> 1;
                        if (cnt == CNT_LAST) begin
                            state <= CAPTURE;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end

                CAPTURE: begin
                    if (!bus.test_mode) begin
                        state <= IDLE;
                    end else begin
                        chain <= bus.ppo;
                        cnt   <= '0;
                        state <= UNLOAD;
                    end
                end

                UNLOAD: begin
                    if (!bus.test_mode) begin
                        state <= IDLE;
                    end else begin
                        resp_sr <= shift_in(resp_sr, chain[0]);
                        chain   <= chain >> 1;
                        if (cnt == CNT_LAST) begin
                            // The last bit lands here; publish the whole word.
                            resp_out <= shift_in(resp_sr, chain[0]);
                            state    <= DONE;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ppi        = chain;
    assign bus.scan_so    = chain[0];
    assign bus.busy       = (state != IDLE);
    assign bus.resp_out   = resp_out;
    assign bus.resp_valid = (state == DONE);

endmodule

// File: tb/tb_scan_ppi_ppo_ctrl.sv
module tb_scan_ppi_ppo_ctrl;
    localparam int N = 4;

    logic clk;
    logic rst_n;
    logic       force_en;
    logic [N-1:0] force_val;
    int n_checks;
    int n_pass;

    scan_ppi_ppo_if #(.N_FF(N)) bus ();

    scan_ppi_ppo_ctrl #(.N_FF(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core stub: next state is the inverse of the present state unless forced.
    always_comb begin
        bus.ppo = force_en ? force_val : ~bus.ppi;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.test_mode = 1'b0;
        bus.start = 1'b0;
        bus.pat_in = '0;
        tick();
        n_checks++;
        if (bus.ppi !== 4'h0) $display("FAIL reset_ppi got %h want 0", bus.ppi); else n_pass++;
        n_checks++;
        if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else n_pass++;
        n_checks++;
        if (bus.resp_valid !== 1'b0) $display("FAIL reset_resp_valid got %b want 0", bus.resp_valid); else n_pass++;
        n_checks++;
        if (bus.resp_out !== 4'h0) $display("FAIL reset_resp_out got %h want 0", bus.resp_out); else n_pass++;
        n_checks++;
        if (bus.scan_so !== 1'b0) $display("FAIL reset_scan_so got %b want 0", bus.scan_so); else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_functional();
        bus.test_mode = 1'b0;
        force_en = 1'b1;
        force_val = 4'hA;
        tick();
        n_checks++;
        if (bus.ppi !== 4'hA) $display("FAIL func_ppi_a got %h want a", bus.ppi); else n_pass++;
        n_checks++;
        if (bus.busy !== 1'b0) $display("FAIL func_busy_a got %b want 0", bus.busy); else n_pass++;
        force_val = 4'h3;
        tick();
        n_checks++;
        if (bus.ppi !== 4'h3) $display("FAIL func_ppi_3 got %h want 3", bus.ppi); else n_pass++;
        n_checks++;
        if (bus.busy !== 1'b0) $display("FAIL func_busy_3 got %b want 0", bus.busy); else n_pass++;
        force_en = 1'b0;
    endtask

    task automatic test_full_sequence();
        logic [3:0] exp_so;
        exp_so = 4'b1010;  // bit i = expected scan_so after unload step i
        bus.test_mode = 1'b1;
        tick();  // test mode, no start: chain holds
        n_checks++;
        if (bus.ppi !== 4'h3) $display("FAIL hold_idle_ppi got %h want 3", bus.ppi); else n_pass++;
        bus.pat_in = 4'h5;
        bus.start = 1'b1;
        tick();  // E0
        bus.start = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b1 || bus.ppi !== 4'h3)
            $display("FAIL accept_edge got busy=%b ppi=%h want busy=1 ppi=3", bus.busy, bus.ppi);
        else n_pass++;
        for (int i = 1; i <= 4; i++) tick();  // E1..E4
        n_checks++;
        if (bus.ppi !== 4'h5) $display("FAIL loaded_ppi got %h want 5", bus.ppi); else n_pass++;
        for (int i = 0; i < 4; i++) begin  // E5..E8
            tick();
            n_checks++;
            if (bus.scan_so !== exp_so[i])
                $display("FAIL scan_so_%0d got %b want %b", i, bus.scan_so, exp_so[i]);
            else n_pass++;
        end
        n_checks++;
        if (bus.resp_valid !== 1'b0) $display("FAIL early_valid got %b want 0", bus.resp_valid); else n_pass++;
        tick();  // E9
        n_checks++;
        if (bus.resp_valid !== 1'b1 || bus.resp_out !== 4'hA)
            $display("FAIL done_e9 got valid=%b resp=%h want valid=1 resp=a", bus.resp_valid, bus.resp_out);
        else n_pass++;
        tick();  // E10
        n_checks++;
        if (bus.resp_valid !== 1'b0 || bus.busy !== 1'b0)
            $display("FAIL after_done got valid=%b busy=%b want 0 0", bus.resp_valid, bus.busy);
        else n_pass++;
    endtask

    task automatic test_start_busy();
        int pulses;
        logic [3:0] seen;
        pulses = 0;
        seen = '0;
        bus.test_mode = 1'b1;
        bus.pat_in = 4'h5;
        bus.start = 1'b1;
        tick();  // E0
        bus.start = 1'b0;
        tick();  // E1
        bus.pat_in = 4'hF;
        bus.start = 1'b1;
        tick();  // E2, ignored start
        bus.start = 1'b0;
        for (int e = 3; e <= 12; e++) begin
            tick();
            if (e == 4) begin
                n_checks++;
                if (bus.ppi !== 4'h5) $display("FAIL busy_load_ppi got %h want 5", bus.ppi); else n_pass++;
            end
            if (bus.resp_valid === 1'b1) begin
                pulses++;
                seen = bus.resp_out;
            end
        end
        n_checks++;
        if (pulses !== 1) $display("FAIL busy_pulses got %0d want 1", pulses); else n_pass++;
        n_checks++;
        if (seen !== 4'hA) $display("FAIL busy_resp got %h want a", seen); else n_pass++;
    endtask

    task automatic test_abort();
        int pulses;
        pulses = 0;
        bus.test_mode = 1'b1;
        bus.pat_in = 4'h6;
        bus.start = 1'b1;
        tick();  // E0
        bus.start = 1'b0;
        for (int e = 1; e <= 6; e++) tick();
        bus.test_mode = 1'b0;
        tick();  // E7: abort, chain holds 4'h4
        n_checks++;
        if (bus.busy !== 1'b0 || bus.resp_valid !== 1'b0)
            $display("FAIL abort_state got busy=%b valid=%b want 0 0", bus.busy, bus.resp_valid);
        else n_pass++;
        n_checks++;
        if (bus.ppi !== 4'h4) $display("FAIL abort_hold got %h want 4", bus.ppi); else n_pass++;
        n_checks++;
        if (bus.resp_out !== 4'hA) $display("FAIL abort_resp got %h want a", bus.resp_out); else n_pass++;
        tick();  // E8: functional capture of ~4
        n_checks++;
        if (bus.ppi !== 4'hB) $display("FAIL abort_func got %h want b", bus.ppi); else n_pass++;
        for (int e = 0; e < 4; e++) begin
            tick();
            if (bus.resp_valid === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses !== 0) $display("FAIL abort_pulses got %0d want 0", pulses); else n_pass++;
    endtask

    task automatic test_reset_mid();
        bus.test_mode = 1'b1;
        bus.pat_in = 4'h6;
        bus.start = 1'b1;
        tick();  // E0
        bus.start = 1'b0;
        for (int e = 1; e <= 4; e++) tick();  // now in CAPTURE
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_checks++;
        if (bus.ppi !== 4'h0 || bus.busy !== 1'b0 || bus.resp_out !== 4'h0 || bus.resp_valid !== 1'b0)
            $display("FAIL midreset got ppi=%h busy=%b resp=%h valid=%b want 0 0 0 0",
                     bus.ppi, bus.busy, bus.resp_out, bus.resp_valid);
        else n_pass++;
        bus.pat_in = 4'h3;
        bus.start = 1'b1;
        tick();  // E0
        bus.start = 1'b0;
        for (int e = 1; e <= 9; e++) tick();
        n_checks++;
        if (bus.resp_valid !== 1'b1 || bus.resp_out !== 4'hC)
            $display("FAIL post_reset_seq got valid=%b resp=%h want 1 c", bus.resp_valid, bus.resp_out);
        else n_pass++;
        tick();
        n_checks++;
        if (bus.busy !== 1'b0) $display("FAIL post_reset_idle got busy=%b want 0", bus.busy); else n_pass++;
    endtask

    task automatic test_back_to_back();
        bus.test_mode = 1'b1;
        bus.pat_in = 4'h0;
        bus.start = 1'b1;
        tick();  // E0
        bus.pat_in = 4'hC;  // start stays high; next accept must come at E11
        for (int e = 1; e <= 9; e++) tick();
        n_checks++;
        if (bus.resp_valid !== 1'b1 || bus.resp_out !== 4'hF)
            $display("FAIL b2b_first got valid=%b resp=%h want 1 f", bus.resp_valid, bus.resp_out);
        else n_pass++;
        tick();  // E10
        n_checks++;
        if (bus.busy !== 1'b0) $display("FAIL b2b_idle got busy=%b want 0", bus.busy); else n_pass++;
        tick();  // E11
        bus.start = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b1) $display("FAIL b2b_accept got busy=%b want 1", bus.busy); else n_pass++;
        for (int e = 12; e <= 19; e++) tick();
        n_checks++;
        if (bus.resp_valid !== 1'b0) $display("FAIL b2b_early got valid=%b want 0", bus.resp_valid); else n_pass++;
        tick();  // E20
        n_checks++;
        if (bus.resp_valid !== 1'b1 || bus.resp_out !== 4'h3)
            $display("FAIL b2b_second got valid=%b resp=%h want 1 3", bus.resp_valid, bus.resp_out);
        else n_pass++;
        tick();  // E21
        n_checks++;
        if (bus.resp_valid !== 1'b0) $display("FAIL b2b_end got valid=%b want 0", bus.resp_valid); else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass = 0;
        force_en = 1'b0;
        force_val = '0;
        rst_n = 1'b0;
        bus.test_mode = 1'b0;
        bus.start = 1'b0;
        bus.pat_in = '0;
        test_reset();
        test_functional();
        test_full_sequence();
        test_start_busy();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
